winograd_tile_feeder: RTL
=========================

Name: winograd_tile_feeder

Overview:
Streaming producer for the 1D Winograd F(2,3) datapath. It accepts a serial stream of signed activation samples over a valid/ready interface and emits overlapping 4-sample input tiles (x1..x4), with stride 2, for the transform/multiply stage. It segments the stream into rows of ROW_LEN samples; tiles never straddle a row boundary. The downstream consumer produces 2 outputs per tile.

Parameters:
DW, 32, sample width in bits (signed two's complement, passed through unmodified)
ROW_LEN, 8, samples per row; must be even and >= 4; elaboration error otherwise
TILES, derived, tiles per row = (ROW_LEN-2)/2, or ROW_LEN/2 with TILE_PAD_EN
TW, derived, tile-index width = max(1, clog2(TILES))

Ports:
clk  in  1  clock; all state is updated on the rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  feeder can accept a sample this cycle
s_data  in  DW  signed input sample
m_valid  out  1  tile valid
m_ready  in  1  downstream accepts the tile
m_x1, m_x2, m_x3, m_x4  out  DW each  tile samples, oldest in m_x1
m_idx  out  TW  tile index within the current row, 0..TILES-1
m_last  out  1  high with the last tile of a row

Behaviour:
- Reset is asynchronous, active-high, and applies to clk.
- Reset values: m_valid=0, m_x1..m_x4=0, m_idx=0, m_last=0, state FILL, fill count 0, tile count 0.
- s_ready is 1 in FILL and STEP, and 0 in TILE. It is purely state-decoded, with no combinational path from m_ready.
- A sample is accepted on a cycle where s_valid and s_ready are both high. It shifts into the window: x1<=x2, x2<=x3, x3<=x4, x4<=s_data.
- FILL (row start): needs 4 accepted samples.
  - On the 4th, the next state is TILE, and m_valid rises the following cycle.
  - Latency is 1 cycle from the 4th accepting edge to m_valid=1.
- TILE: m_valid=1; m_x*, m_idx and m_last are held stable until m_ready=1.
  - m_ready with m_last=0: the tile count increments and the next state is STEP. The window keeps x3,x4 as the new x1,x2.
  - m_ready with m_last=1: the tile count resets to 0 and the next state is FILL. Stale window contents are discarded.
- STEP: needs 2 accepted samples. On the 2nd, the next state is TILE.
- m_last = (tile count == TILES-1). m_idx = tile count.
- Peak throughput is 1 tile per 3 cycles, since TILE occupies a cycle.
- s_valid gaps stall FILL/STEP indefinitely, with no timeout.
- m_ready asserted outside TILE is ignored.
- Reset mid-row discards the partial window and tile count. The first post-reset sample is row sample 0.
- No arithmetic is performed; samples are bit-exact copies, and sign is preserved.

Optional Feature:
Macro TILE_PAD_EN enables "same" padding: one zero sample is implicitly inserted before and after each row, so TILES = ROW_LEN/2. The zeros consume no s handshake.
- In FILL, the window is preloaded with x4=0 and needs only 3 accepted samples.
- For the last tile, STEP needs 1 accepted sample; then a 0 is shifted in internally on the next cycle (s_ready=0 that cycle) before entering TILE.
- Without the macro: no padding, TILES=(ROW_LEN-2)/2, and the FILL/STEP behaviour is exactly as above.

Test Plan:
1. ROW_LEN=8, stream 1..8 with s_valid always 1 and m_ready always 1 -> tiles (1,2,3,4) idx0, (3,4,5,6) idx1, (5,6,7,8) idx2 with m_last=1. m_valid is first high 1 cycle after sample 4 is accepted.
2. Back-to-back rows 1..16 -> 4th tile is (9,10,11,12) with idx0, m_last=0. No tile contains 7 or 8 together with 9; 6 tiles in total.
3. Backpressure: m_ready=0 for 5 cycles during tile (3,4,5,6) -> m_valid, m_x*, m_idx stay constant, s_ready=0 throughout, and no sample is lost; the next tile is (5,6,7,8).
4. Signed data: samples -1, 0x80000000, 0x7FFFFFFF, -5 -> m_x1..m_x4 exactly equal those values.
5. Assert rst after 3 samples, release, then stream 10..17 -> first tile is (10,11,12,13) idx0; m_valid=0 during and immediately after reset.
6. TILE_PAD_EN, ROW_LEN=8, stream 1..8 -> tiles (0,1,2,3), (2,3,4,5), (4,5,6,7), (6,7,8,0) with m_last on the 4th; exactly 8 input handshakes.

Source files
------------

// File: rtl/winograd_tile_feeder.sv
// winograd_tile_feeder: F(2,3) 4-sample stride-2 tile feeder per row; TILE_PAD_EN adds zero padding at row edges
module winograd_tile_feeder #(
  parameter int DW = 32,
  parameter int ROW_LEN = 8,
`ifdef TILE_PAD_EN
  localparam int TILES = ROW_LEN / 2,
  localparam bit PAD = 1'b1,
`else
  localparam int TILES = (ROW_LEN - 2) / 2,
  localparam bit PAD = 1'b0,
`endif
  localparam int TW = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_x1,
  output logic [DW-1:0] m_x2,
  output logic [DW-1:0] m_x3,
  output logic [DW-1:0] m_x4,
  output logic [TW-1:0] m_idx,
  output logic          m_last
);
  if (ROW_LEN % 2 != 0 || ROW_LEN < 4) begin : g_bad_row_len
    $error("winograd_tile_feeder: ROW_LEN must be even and >= 4");
  end
  typedef enum logic [1:0] {FILL, TILE, STEP, ZPAD} state_e;
  localparam logic [TW-1:0] LAST = TW'(TILES - 1);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d, need;
  logic [TW-1:0] tile_q, tile_d;
  logic [DW-1:0] x_q [4];
  logic [DW-1:0] x_d [4];
  logic accept, step_last;
  assign s_ready = state_q == FILL || state_q == STEP;
  assign m_valid = state_q == TILE;
  assign m_x1 = x_q[0];
  assign m_x2 = x_q[1];
  assign m_x3 = x_q[2];
  assign m_x4 = x_q[3];
  assign m_idx = tile_q;
  assign m_last = tile_q == LAST;
  assign accept = s_valid && s_ready;
  // with padding the final step takes one real sample; the trailing zero is shifted in by ZPAD
  assign step_last = PAD && tile_q == LAST;
  assign need = state_q == FILL ? (PAD ? 2'd2 : 2'd3) : (step_last ? 2'd0 : 2'd1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tile_d = tile_q;
    x_d = x_q;
    if (accept) begin
      x_d = '{x_q[1], x_q[2], x_q[3], s_data};
      cnt_d = cnt_q == need ? 2'd0 : cnt_q + 2'd1;
      if (cnt_q == need) state_d = (state_q == STEP && step_last) ? ZPAD : TILE;
    end
    if (state_q == ZPAD) begin
      x_d = '{x_q[1], x_q[2], x_q[3], '0};
      state_d = TILE;
    end
    if (state_q == TILE && m_ready) begin
      tile_d = m_last ? '0 : tile_q + TW'(1);
      state_d = m_last ? FILL : STEP;
      if (PAD && m_last) x_d[3] = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q <= '0;
      tile_q <= '0;
      x_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tile_q <= tile_d;
      x_q <= x_d;
    end
  end
endmodule
